// File: rtl/serial_adder_n.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : serial_adder_n
//  Purpose  : Bit-serial two's-complement adder/subtractor. Processes one bit
//             per clock, LSB first, over WIDTH cycles. Results are registered
//             and held until the next operation completes.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH    operand/result width in bits (legal range 2..32)
//  Ports
//    clk      rising-edge clock
//    rst_n    asynchronous active-low reset
//    start_i  request a new operation (ignored while busy)
//    a_i      first operand, captured on accepted start
//    b_i      second operand, captured on accepted start
//    cin_i    carry-in for add mode (ignored when subtracting)
//    sub_i    0 = a+b+cin, 1 = a-b
//    s_o      registered result
//    cout_o   final carry-out (subtract: 1 = no borrow)
//    ovf_o    signed overflow flag
//    busy_o   high while bits are being processed
//    done_o   one-cycle pulse when s_o/cout_o/ovf_o update
//  Configuration
//    SERIAL_ADDER_OVF_EN  when defined, ovf_o reports signed overflow;
//                         otherwise ovf_o is tied low.
// ============================================================================
module serial_adder_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] s_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int                CNT_W      = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  C_LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic [WIDTH-1:0]   res_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   s_q;
    logic               cout_q;
    logic               busy_q;
    logic               done_q;

    // Full-adder slice evaluated on the current LSBs each RUN cycle
    logic               sum_d;
    logic               carry_d;
    logic [WIDTH-1:0]   res_d;

    always_comb begin
        sum_d   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        carry_d = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
        // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at LSB
        res_d   = {sum_d, res_q[WIDTH-1:1]};
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic               ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        // Subtraction is a + ~b + 1, so cin is replaced by 1
                        a_sh_q  <= a_i;
                        b_sh_q  <= sub_i ? ~b_i : b_i;
                        carry_q <= sub_i ? 1'b1 : cin_i;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // start_i is deliberately not looked at here
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    carry_q <= carry_d;
                    res_q   <= res_d;
                    cnt_q   <= cnt_q + C_CNT_ONE;
                    if (cnt_q == C_LAST_BIT) begin
                        s_q     <= res_d;
                        cout_q  <= carry_d;
`ifdef SERIAL_ADDER_OVF_EN
                        // On the MSB slice carry_q is the carry into the MSB
                        ovf_q   <= carry_q ^ carry_d;
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_o    = s_q;
    assign cout_o = cout_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf_o  = ovf_q;
`else
    assign ovf_o  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_n.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder_n
//  Purpose  : Self-checking bench for serial_adder_n (WIDTH = 8). Vector table
//             plus hand-written sequences for start-during-run, back-to-back
//             operation and mid-operation reset. Expected results go into a
//             scoreboard queue when start is driven and are popped on done.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_adder_n;

    localparam int W = 8;
`ifdef SERIAL_ADDER_OVF_EN
    localparam logic OV = 1'b1;
`else
    localparam logic OV = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         start_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         cin_i;
    logic         sub_i;
    logic [W-1:0] s_o;
    logic         cout_o;
    logic         ovf_o;
    logic         busy_o;
    logic         done_o;

    serial_adder_n #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .cin_i   (cin_i),
        .sub_i   (sub_i),
        .s_o     (s_o),
        .cout_o  (cout_o),
        .ovf_o   (ovf_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t         sb_q[$];
    vec_t         vecs[12];
    int           n_total = 0;
    int           n_bad   = 0;
    logic [W-1:0] last_s  = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", nm, act, req, $time);
        end
    endtask

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, input logic sub,
                                input logic [W-1:0] s, input logic cout, input logic ovf);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.sub = sub;
        v.s = s; v.cout = cout; v.ovf = ovf;
        return v;
    endfunction

    // Drive one operation at the next falling edge; push its expectation
    task automatic launch(input vec_t v);
        @(negedge clk);
        a_i = v.a; b_i = v.b; cin_i = v.cin; sub_i = v.sub;
        start_i = 1'b1;
        sb_q.push_back({v.s, v.cout, v.ovf});
    endtask

    // Full operation with latency checks; returns in the done cycle
    task automatic do_op(input vec_t v);
        launch(v);
        @(negedge clk);
        start_i = 1'b0;
        for (int c = 1; c <= W; c++) begin
            chk("run_busy", busy_o, 1);
            chk("run_no_done", done_o, 0);
            chk("run_s_hold", s_o, last_s);
            @(negedge clk);
        end
        chk("done_latency", done_o, 1);
        chk("done_busy_low", busy_o, 0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy_done_excl", busy_o & done_o, 0);
            if (done_o) begin
                chk("sb_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("res_s", s_o, e.s);
                    chk("res_cout", cout_o, e.cout);
                    chk("res_ovf", ovf_o, e.ovf);
                    last_s = e.s;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcount;
        vecs[0]  = mk(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
        vecs[1]  = mk(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        vecs[2]  = mk(8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
        vecs[3]  = mk(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        vecs[4]  = mk(8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
        vecs[5]  = mk(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, OV);
        vecs[6]  = mk(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, OV);
        vecs[7]  = mk(8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        vecs[8]  = mk(8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
        vecs[9]  = mk(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, OV);
        vecs[10] = mk(8'h3C, 8'h4D, 1'b0, 1'b0, 8'h89, 1'b0, OV);
        vecs[11] = mk(8'h12, 8'h34, 1'b0, 1'b1, 8'hDE, 1'b0, 1'b0);

        rst_n = 1'b0; start_i = 1'b0;
        a_i = '0; b_i = '0; cin_i = 1'b0; sub_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_s", s_o, 0);
        chk("rst_cout", cout_o, 0);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy_o, 0);

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i]);
        end

        // start pulsed at k+3 while running must be ignored
        launch(mk(8'h21, 8'h13, 1'b0, 1'b0, 8'h34, 1'b0, 1'b0));
        @(negedge clk); start_i = 1'b0;               // k+1
        @(negedge clk);                               // k+2
        @(negedge clk);                               // k+3
        a_i = 8'hFF; b_i = 8'hFF; sub_i = 1'b1; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0; sub_i = 1'b0; // k+4
        dcount = 0;
        for (int c = 4; c <= 12; c++) begin
            if (c > 4) @(negedge clk);
            if (done_o) begin
                dcount++;
                chk("ign_done_cycle", c, 9);
            end
        end
        chk("ign_done_count", dcount, 1);

        // back-to-back: start held during the DONE cycle
        launch(mk(8'h40, 8'h02, 1'b0, 1'b0, 8'h42, 1'b0, 1'b0));
        @(negedge clk); start_i = 1'b0;               // k+1
        repeat (8) @(negedge clk);                    // k+9
        chk("b2b_first_done", done_o, 1);
        a_i = 8'h50; b_i = 8'h10; cin_i = 1'b1; sub_i = 1'b1; start_i = 1'b1;
        sb_q.push_back({8'h40, 1'b1, 1'b0});
        @(negedge clk); start_i = 1'b0;               // k+10
        chk("b2b_busy", busy_o, 1);
        repeat (7) @(negedge clk);                    // k+17
        chk("b2b_not_early", done_o, 0);
        @(negedge clk);                               // k+18
        chk("b2b_second_done", done_o, 1);

        // asynchronous reset in the middle of an operation
        launch(mk(8'h99, 8'h11, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b0));
        @(negedge clk); start_i = 1'b0;               // k+1
        repeat (3) @(negedge clk);                    // k+4
        chk("pre_rst_busy", busy_o, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_s", s_o, 0);
        chk("arst_cout", cout_o, 0);
        chk("arst_ovf", ovf_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_done", done_o, 0);
        sb_q.delete();
        last_s = '0;
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int c = 0; c < W + 3; c++) begin
            @(negedge clk);
            if (done_o) dcount++;
        end
        chk("rst_no_done", dcount, 0);
        do_op(mk(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0));

        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
